turn_sequencer_n: RTL and testbench
===================================

# turn_sequencer_n

Parametrised turn-sequencing controller for N-player board games (tic-tac-toe and larger variants). It grants the move to one player at a time and hands each requested move to the board checker for a one-cycle evaluation. Based on the checker's verdict it commits the move and advances to the next player, or ends the game with a win or a draw. It adds an optional per-turn timeout with forfeit, and sits between the player input debouncers and the board/win-check datapath.

## Interface
- NUM_PLAYERS, 2: number of players, ≥2; players indexed 0..NUM_PLAYERS-1.
- FIRST_PLAYER, 0: player granted the first turn of every game; must be < NUM_PLAYERS.
- TIMEOUT_CYCLES, 0: cycles a player may idle in its turn before forfeiting it; 0 disables timeout.
- PW (derived, not overridable): max(1, $clog2(NUM_PLAYERS)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a new game; honoured in IDLE and OVER only.
- move_req  in  NUM_PLAYERS  per-player move request, level.
- illegal_move  in  1  checker verdict, sampled in CHECK.
- winner  in  1  checker verdict, sampled in CHECK.
- no_space  in  1  checker verdict, sampled in CHECK.
- player_turn  out  NUM_PLAYERS  one-hot grant; zero outside WAIT.
- active_player  out  PW  index of the player to move or being checked.
- check_req  out  1  high during CHECK; checker evaluates active_player's move.
- move_commit  out  1  one-cycle pulse: legal move accepted.
- illegal_flag  out  1  one-cycle pulse: move rejected, same player retries.
- timeout_flag  out  1  one-cycle pulse: turn forfeited.
- game_over  out  1  high in OVER.
- win_flag  out  1  game ended by a win; valid while game_over.
- draw_flag  out  1  game ended by a draw; valid while game_over.
- winner_id  out  PW  winning player; valid while win_flag.

## Operation
- States: IDLE, WAIT, CHECK, OVER. All outputs are registered.
- Reset (async, reset=0): go to IDLE; every output is 0, active_player=0, timer=0. Reset mid-game aborts the game with no commit pulse.
- IDLE: all outputs are 0.
  - start=1 → WAIT, active_player=FIRST_PLAYER, timer=0.
- WAIT: player_turn=onehot(active_player). Only move_req[active_player] is considered; other bits are ignored.
  - Request seen → CHECK, timer cleared.
  - Otherwise the timer increments. If TIMEOUT_CYCLES≠0 and timer==TIMEOUT_CYCLES-1: timeout_flag pulses, active_player advances, timer=0, stay in WAIT.
  - A request and a timeout in the same cycle: the request wins and no timeout occurs.
- CHECK (exactly one cycle): check_req=1, player_turn=0. Verdict priority is illegal_move > winner > no_space.
  - illegal_move → WAIT, same player, illegal_flag pulse, no commit.
  - winner → OVER, move_commit pulse, win_flag=1, winner_id=active_player.
  - no_space → OVER, move_commit pulse, draw_flag=1.
  - Otherwise → WAIT, move_commit pulse, active_player advances.
- Advance: active_player+1, wrapping NUM_PLAYERS-1 → 0.
- OVER: game_over, win_flag, draw_flag and winner_id hold their values.
  - start=1 → WAIT, flags cleared, active_player=FIRST_PLAYER.
- start is ignored in WAIT and CHECK.

## Timing
- Cycle t: WAIT with move_req[active]=1.
- Cycle t+1: CHECK, check_req=1. Verdict inputs must be valid this cycle.
- Cycle t+2: move_commit/illegal_flag high for this cycle only; the next player_turn, or game_over, is visible this cycle.
- Minimum turn period: 2 cycles.
- Timeout: a player granted at cycle g with no request forfeits; timeout_flag is high at cycle g+TIMEOUT_CYCLES, the same cycle the next player's grant appears.
- TIMEOUT_CYCLES=1: every WAIT cycle without a request forfeits.
- A move_req held high across turns is consumed only by its owner's next grant.
- start → first grant: 1 cycle.

## Test plan
- NUM_PLAYERS=2: reset low, then start. player_turn=2'b01 one cycle later. move_req=01 with all verdicts 0 → commit pulse 2 cycles after the request, player_turn=2'b10.
- illegal_move=1 in CHECK → illegal_flag pulse, no move_commit, player_turn returns to the same player.
- NUM_PLAYERS=3: three legal moves → active_player sequence 0,1,2,0 (wrap-around).
- winner=1 and no_space=1 together in CHECK for player 1 → game_over=1, win_flag=1, draw_flag=0, winner_id=1. start then → player_turn=onehot(FIRST_PLAYER) and flags clear.
- TIMEOUT_CYCLES=4, no requests: timeout_flag every 4 cycles, grant rotates. A request arriving in the 4th cycle → CHECK, no timeout_flag.
- Reset asserted during CHECK → every output 0 immediately (asynchronously). move_req from non-active players has no effect.

Source files
------------

// File: rtl/turn_sequencer_n.sv
// Turn-sequencing controller for N-player board games: grants one player at a time,
// hands the move to the board checker for one cycle, then commits, retries, forfeits or ends the game.
module turn_sequencer_n #(
  parameter int NUM_PLAYERS    = 2,
  parameter int FIRST_PLAYER   = 0,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_PLAYERS-1:0] move_req,
  input  logic                   illegal_move,
  input  logic                   winner,
  input  logic                   no_space,
  output logic [NUM_PLAYERS-1:0] player_turn,
  output logic [PW-1:0]          active_player,
  output logic                   check_req,
  output logic                   move_commit,
  output logic                   illegal_flag,
  output logic                   timeout_flag,
  output logic                   game_over,
  output logic                   win_flag,
  output logic                   draw_flag,
  output logic [PW-1:0]          winner_id
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] FIRST   = PW'(FIRST_PLAYER);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic          TO_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          active_q, active_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [NUM_PLAYERS-1:0] player_turn_q, player_turn_d;
  logic                   check_req_q, check_req_d;
  logic                   move_commit_q, move_commit_d;
  logic                   illegal_flag_q, illegal_flag_d;
  logic                   timeout_flag_q, timeout_flag_d;
  logic                   game_over_q, game_over_d;
  logic                   win_flag_q, win_flag_d;
  logic                   draw_flag_q, draw_flag_d;
  logic [PW-1:0]          winner_id_q, winner_id_d;

  function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
    if (p == PW'(NUM_PLAYERS - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  function automatic logic [NUM_PLAYERS-1:0] onehot(input logic [PW-1:0] p);
    return {{(NUM_PLAYERS-1){1'b0}}, 1'b1} << p;
  endfunction

  // Every output is registered, so the next-cycle output values are computed here
  // together with the next state.
  always_comb begin
    state_d        = state_q;
    active_d       = active_q;
    timer_d        = timer_q;
    player_turn_d  = '0;
    check_req_d    = 1'b0;
    move_commit_d  = 1'b0;
    illegal_flag_d = 1'b0;
    timeout_flag_d = 1'b0;
    game_over_d    = game_over_q;
    win_flag_d     = win_flag_q;
    draw_flag_d    = draw_flag_q;
    winner_id_d    = winner_id_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = WAIT;
          active_d      = FIRST;
          timer_d       = '0;
          player_turn_d = onehot(FIRST);
        end
      end

      WAIT: begin
        // A request in the timer's last cycle beats the forfeit.
        if (move_req[active_q]) begin
          state_d     = CHECK;
          timer_d     = '0;
          check_req_d = 1'b1;
        end else if (TO_EN && (timer_q == TO_LAST)) begin
          timeout_flag_d = 1'b1;
          active_d       = next_player(active_q);
          timer_d        = '0;
          player_turn_d  = onehot(next_player(active_q));
        end else begin
          timer_d       = timer_q + 1'b1;
          player_turn_d = onehot(active_q);
        end
      end

      CHECK: begin
        timer_d = '0;
        if (illegal_move) begin
          state_d        = WAIT;
          illegal_flag_d = 1'b1;
          player_turn_d  = onehot(active_q);
        end else if (winner) begin
          state_d       = OVER;
          move_commit_d = 1'b1;
          game_over_d   = 1'b1;
          win_flag_d    = 1'b1;
          winner_id_d   = active_q;
        end else if (no_space) begin
          state_d       = OVER;
          move_commit_d = 1'b1;
          game_over_d   = 1'b1;
          draw_flag_d   = 1'b1;
        end else begin
          state_d       = WAIT;
          move_commit_d = 1'b1;
          active_d      = next_player(active_q);
          player_turn_d = onehot(next_player(active_q));
        end
      end

      OVER: begin
        if (start) begin
          state_d       = WAIT;
          active_d      = FIRST;
          timer_d       = '0;
          player_turn_d = onehot(FIRST);
          game_over_d   = 1'b0;
          win_flag_d    = 1'b0;
          draw_flag_d   = 1'b0;
          winner_id_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      active_q       <= '0;
      timer_q        <= '0;
      player_turn_q  <= '0;
      check_req_q    <= 1'b0;
      move_commit_q  <= 1'b0;
      illegal_flag_q <= 1'b0;
      timeout_flag_q <= 1'b0;
      game_over_q    <= 1'b0;
      win_flag_q     <= 1'b0;
      draw_flag_q    <= 1'b0;
      winner_id_q    <= '0;
    end else begin
      state_q        <= state_d;
      active_q       <= active_d;
      timer_q        <= timer_d;
      player_turn_q  <= player_turn_d;
      check_req_q    <= check_req_d;
      move_commit_q  <= move_commit_d;
      illegal_flag_q <= illegal_flag_d;
      timeout_flag_q <= timeout_flag_d;
      game_over_q    <= game_over_d;
      win_flag_q     <= win_flag_d;
      draw_flag_q    <= draw_flag_d;
      winner_id_q    <= winner_id_d;
    end
  end

  assign player_turn   = player_turn_q;
  assign active_player = active_q;
  assign check_req     = check_req_q;
  assign move_commit   = move_commit_q;
  assign illegal_flag  = illegal_flag_q;
  assign timeout_flag  = timeout_flag_q;
  assign game_over     = game_over_q;
  assign win_flag      = win_flag_q;
  assign draw_flag     = draw_flag_q;
  assign winner_id     = winner_id_q;

endmodule

// File: tb/tb_turn_sequencer_n.sv
// Bench for turn_sequencer_n: directed scenarios plus randomized play against a
// game-level reference model (3 players, first player 1, 4-cycle turn timeout).
module tb_turn_sequencer_n;

  localparam int N  = 3;
  localparam int FP = 1;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset, start, illegal_move, winner, no_space;
  logic [2:0] move_req;
  logic [2:0] player_turn;
  logic [1:0] active_player, winner_id;
  logic       check_req, move_commit, illegal_flag, timeout_flag;
  logic       game_over, win_flag, draw_flag;

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the game, kept in plain game terms.
  bit m_in_game, m_in_check, m_finished, m_commit, m_illegal, m_timeout, m_win, m_draw;
  int m_cur, m_wid, m_idle;

  turn_sequencer_n #(.NUM_PLAYERS(N), .FIRST_PLAYER(FP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .move_req(move_req),
    .illegal_move(illegal_move), .winner(winner), .no_space(no_space),
    .player_turn(player_turn), .active_player(active_player), .check_req(check_req),
    .move_commit(move_commit), .illegal_flag(illegal_flag), .timeout_flag(timeout_flag),
    .game_over(game_over), .win_flag(win_flag), .draw_flag(draw_flag), .winner_id(winner_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_in_game = 0; m_in_check = 0; m_finished = 0; m_commit = 0; m_illegal = 0;
    m_timeout = 0; m_win = 0; m_draw = 0; m_cur = 0; m_wid = 0; m_idle = 0;
  endtask

  task automatic model_step();
    m_commit = 0; m_illegal = 0; m_timeout = 0;
    if (m_in_game && m_in_check) begin
      m_in_check = 0;
      m_idle = 0;
      if (illegal_move) m_illegal = 1;
      else begin
        m_commit = 1;
        if (winner) begin
          m_in_game = 0; m_finished = 1; m_win = 1; m_wid = m_cur;
        end else if (no_space) begin
          m_in_game = 0; m_finished = 1; m_draw = 1;
        end else m_cur = (m_cur + 1) % N;
      end
    end else if (m_in_game) begin
      if (move_req[m_cur]) begin
        m_in_check = 1; m_idle = 0;
      end else begin
        m_idle++;
        if (TO != 0 && m_idle == TO) begin
          m_timeout = 1; m_cur = (m_cur + 1) % N; m_idle = 0;
        end
      end
    end else if (start) begin
      m_in_game = 1; m_finished = 0; m_win = 0; m_draw = 0; m_wid = 0; m_cur = FP; m_idle = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; move_req = '0; illegal_move = 1'b0; winner = 1'b0; no_space = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({player_turn, active_player, check_req, move_commit, illegal_flag, timeout_flag,
         game_over, win_flag, draw_flag, winner_id} !== 14'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got turn=%b act=%0d chk=%b over=%b, want all 0",
               player_turn, active_player, check_req, game_over);
    end
    @(negedge clk) reset = 1'b1;
    tick();
    n_vec++;
    if ({player_turn, check_req, game_over} !== 5'b0) begin
      n_err++;
      $display("FAIL idle_no_start: got turn=%b chk=%b over=%b, want 0", player_turn, check_req, game_over);
    end
  endtask

  task automatic test_first_move();
    start = 1'b1; tick(); start = 1'b0;
    n_vec++;
    if (player_turn !== 3'b010 || active_player !== 2'd1) begin
      n_err++;
      $display("FAIL first_grant: got turn=%b act=%0d, want 010 act=1", player_turn, active_player);
    end
    move_req = 3'b010; tick(); move_req = '0;
    n_vec++;
    if (check_req !== 1'b1 || player_turn !== 3'b000) begin
      n_err++;
      $display("FAIL check_cycle: got chk=%b turn=%b, want chk=1 turn=000", check_req, player_turn);
    end
    tick();
    n_vec++;
    if (move_commit !== 1'b1 || player_turn !== 3'b100 || active_player !== 2'd2) begin
      n_err++;
      $display("FAIL commit: got commit=%b turn=%b act=%0d, want 1 100 2", move_commit, player_turn, active_player);
    end
    tick();
    n_vec++;
    if (move_commit !== 1'b0) begin
      n_err++;
      $display("FAIL commit_pulse: got commit=%b one cycle later, want 0", move_commit);
    end
  endtask

  task automatic test_illegal();
    move_req = 3'b100; tick(); move_req = '0;
    illegal_move = 1'b1; tick(); illegal_move = 1'b0;
    n_vec++;
    if (illegal_flag !== 1'b1 || move_commit !== 1'b0 || player_turn !== 3'b100 || active_player !== 2'd2) begin
      n_err++;
      $display("FAIL illegal: got ill=%b commit=%b turn=%b act=%0d, want 1 0 100 2",
               illegal_flag, move_commit, player_turn, active_player);
    end
    tick();
    n_vec++;
    if (illegal_flag !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_pulse: got ill=%b, want 0", illegal_flag);
    end
  endtask

  task automatic test_wrap();
    int seq[3] = '{0, 1, 2};
    int cur = 2;
    for (int k = 0; k < 3; k++) begin
      move_req = 3'(1 << cur); tick(); move_req = '0;
      tick();
      n_vec++;
      if (move_commit !== 1'b1 || active_player !== 2'(seq[k])) begin
        n_err++;
        $display("FAIL wrap step %0d: got commit=%b act=%0d, want 1 act=%0d", k, move_commit, active_player, seq[k]);
      end
      cur = seq[k];
    end
  endtask

  task automatic test_win_priority();
    move_req = 3'b100; tick(); move_req = '0; tick();
    move_req = 3'b001; tick(); move_req = '0; tick();
    move_req = 3'b010; tick(); move_req = '0;
    winner = 1'b1; no_space = 1'b1; tick(); winner = 1'b0; no_space = 1'b0;
    n_vec++;
    if ({game_over, win_flag, draw_flag} !== 3'b110 || winner_id !== 2'd1 || move_commit !== 1'b1 || player_turn !== 3'b000) begin
      n_err++;
      $display("FAIL win: got over/win/draw=%b wid=%0d commit=%b turn=%b, want 110 1 1 000",
               {game_over, win_flag, draw_flag}, winner_id, move_commit, player_turn);
    end
    tick();
    n_vec++;
    if ({game_over, win_flag, draw_flag} !== 3'b110 || winner_id !== 2'd1 || move_commit !== 1'b0) begin
      n_err++;
      $display("FAIL win_hold: got over/win/draw=%b wid=%0d commit=%b, want 110 1 0",
               {game_over, win_flag, draw_flag}, winner_id, move_commit);
    end
    start = 1'b1; tick(); start = 1'b0;
    n_vec++;
    if (player_turn !== 3'b010 || {game_over, win_flag, draw_flag} !== 3'b000 || active_player !== 2'd1) begin
      n_err++;
      $display("FAIL restart: got turn=%b flags=%b act=%0d, want 010 000 1",
               player_turn, {game_over, win_flag, draw_flag}, active_player);
    end
  endtask

  task automatic test_timeout();
    logic [2:0] want_turn;
    logic       want_to;
    for (int c = 1; c <= 8; c++) begin
      tick();
      want_to   = (c == 4 || c == 8);
      want_turn = (c < 4) ? 3'b010 : (c < 8) ? 3'b100 : 3'b001;
      n_vec++;
      if (timeout_flag !== want_to || player_turn !== want_turn) begin
        n_err++;
        $display("FAIL timeout cycle %0d: got to=%b turn=%b, want to=%b turn=%b",
                 c, timeout_flag, player_turn, want_to, want_turn);
      end
    end
  endtask

  task automatic test_req_last_cycle();
    repeat (3) tick();
    move_req = 3'b001; tick(); move_req = '0;
    n_vec++;
    if (check_req !== 1'b1 || timeout_flag !== 1'b0) begin
      n_err++;
      $display("FAIL req_vs_timeout: got chk=%b to=%b, want chk=1 to=0", check_req, timeout_flag);
    end
  endtask

  task automatic test_async_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({player_turn, active_player, check_req, move_commit, illegal_flag, timeout_flag,
         game_over, win_flag, draw_flag, winner_id} !== 14'b0) begin
      n_err++;
      $display("FAIL async_reset: got turn=%b act=%0d chk=%b commit=%b, want all 0",
               player_turn, active_player, check_req, move_commit);
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_nonactive();
    start = 1'b1; tick(); start = 1'b0;
    move_req = 3'b101;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (check_req !== 1'b0 || player_turn !== 3'b010) begin
        n_err++;
        $display("FAIL nonactive cycle %0d: got chk=%b turn=%b, want chk=0 turn=010", c, check_req, player_turn);
      end
    end
    move_req = '0;
  endtask

  task automatic test_random();
    logic [13:0] got, want;
    reset = 1'b0; #1; model_reset();
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      start        = ($urandom_range(0, 15) == 0);
      move_req     = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      illegal_move = ($urandom_range(0, 3) == 0);
      winner       = ($urandom_range(0, 7) == 0);
      no_space     = ($urandom_range(0, 7) == 0);
      tick();
      got  = {player_turn, active_player, check_req, move_commit, illegal_flag, timeout_flag,
              game_over, win_flag, draw_flag, (win_flag ? winner_id : 2'b00)};
      want = {((m_in_game && !m_in_check) ? 3'(1 << m_cur) : 3'b000), 2'(m_cur), m_in_check,
              m_commit, m_illegal, m_timeout, m_finished, m_win, m_draw, (m_win ? 2'(m_wid) : 2'b00)};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL random cycle %0d: got %b want %b (turn,act,chk,commit,ill,to,over,win,draw,wid)", i, got, want);
      end
    end
    start = 1'b0; move_req = '0; illegal_move = 1'b0; winner = 1'b0; no_space = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_illegal();
    test_wrap();
    test_win_priority();
    test_timeout();
    test_req_last_cycle();
    test_async_reset();
    test_nonactive();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
